disp_value_src: RTL
===================

// Module: disp_value_src
// PURPOSE
//   Upstream feeder for the 4-digit hex display. Captures the 32-bit value the
//   multicycle CPU writes to its display register. Drives one 16-bit half (page)
//   of that value onto the display's data[15:0] input.
//   A debounced push-button steps through the pages; a hold input freezes the shown value.
// PARAMETERS
//   DEB_CYCLES  1_000_000     consecutive stable cycles before a button level is accepted (10 ms @ 100 MHz)
//   RESET_VALUE 32'h0000_0000 value held in the capture register after reset
// PORTS
//   clk       in   1   system clock; only clock in the block
//   reset     in   1   asynchronous, active-low reset (0 = reset)
//   wr_en     in   1   CPU display-register write strobe, one cycle per write
//   wr_data   in   32  CPU write data, sampled when wr_en=1
//   btn_page  in   1   raw, bouncing, asynchronous page push-button (1 = pressed)
//   hold      in   1   level; 1 = freeze data output
//   data      out  16  value for the hex display, registered
//   page      out  2   current page index (drives status LEDs)
// BEHAVIOUR
//   - Reset (reset=0, async): capture=RESET_VALUE, page=0, data=RESET_VALUE[15:0], debouncer cleared (stable level 0, counter 0).
//   - Capture: wr_en=1 -> capture<=wr_data at that edge. Writes are accepted regardless of hold.
//   - Page button: 2-FF synchroniser, then debounce counter.
//       - Counter counts while the synced level differs from the stable level; it clears to 0 on any match.
//       - When the count reaches DEB_CYCLES-1, the stable level takes the synced level and the counter clears.
//       - A 0->1 change of the stable level gives a one-cycle press pulse. Releases produce no pulse.
//       - Press latency: 2 sync + DEB_CYCLES cycles from a clean input edge.
//   - Page step on press pulse: 0->1->0 (wraps). With DISP_WR_COUNT_EN: 0->1->2->0.
//   - Output mux: page0=capture[15:0], page1=capture[31:16], page2=write count.
//       - data is registered and reflects capture/page state one cycle after the edge that updates them.
//   - Simultaneous wr_en and press: both take effect on the same edge. Next cycle, data shows the new value on the new page.
//   - hold=1: data register keeps its value. page and capture still update. On hold 1->0, data shows the current selection 1 cycle later.
//   - Reset mid-debounce: pending count is discarded; no press pulse is issued.
// CONFIGURATION
//   DISP_WR_COUNT_EN defined:
//     - adds a 16-bit counter, incremented on each wr_en, wrapping 16'hFFFF->0, reset to 0
//     - adds page 2, which shows the counter
//   DISP_WR_COUNT_EN undefined:
//     - no counter logic
//     - page[1] tied 0
//     - page value 2 unreachable
// STRUCTURE
//   Shared package disp_pkg:
//     - PAGE_LO=2'd0, PAGE_HI=2'd1, PAGE_CNT=2'd2
//     - DISP_W=16, CAP_W=32
//   Sub-module btn_debounce (synchroniser + counter + press pulse). Parameters: DEB_CYCLES. Ports: clk, reset, btn_raw, level, press.
//     - Also reusable for other board buttons.
//   Top: capture register, page FSM, optional counter, output mux/register.
// TESTING (benches override DEB_CYCLES=4)
//   1. Reset
//      - reset=0 mid-run -> data=16'h0000, page=0 immediately (async).
//   2. Capture and page step
//      - wr_en with wr_data=32'hDEAD_BEEF, then clean press -> data=16'hBEEF, then 16'hDEAD.
//      - page 0->1 exactly 2+4 cycles after the press edge.
//   3. Bounce rejection
//      - btn_page toggles every 2 cycles for 20 cycles, then stays 1 -> exactly one page step.
//      - Holding the button for 100 cycles gives no further steps; release gives no step.
//   4. Simultaneous events and hold
//      - wr_en(32'h1234_5678) on the same edge as the press pulse, from page 0 -> next cycle data=16'h1234.
//      - hold=1, then write 32'hAAAA_BBBB -> data unchanged.
//      - hold=0 -> 16'hAAAA one cycle later.
//   5. Write counter (DISP_WR_COUNT_EN)
//      - 3 writes, step to page 2 -> data=16'h0003.
//      - Preload 16'hFFFF, 1 write -> 16'h0000.
//      - Without the macro: 4 presses give page sequence 1,0,1,0.
//   6. Reset mid-debounce
//      - Press, assert reset at count 2, release reset with the button still pressed -> no step until a full 2+4 stable cycles have elapsed after reset.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and widths for the hex-display value source.
// DISP_WR_COUNT_EN adds the write-count page to the page sequence.
package disp_pkg;

  localparam int DISP_W = 16;
  localparam int CAP_W  = 32;

  typedef enum logic [1:0] {
    PAGE_LO  = 2'd0,
    PAGE_HI  = 2'd1,
    PAGE_CNT = 2'd2
  } page_e;

  // Page order on each press; the write-count page only exists with the counter
  function automatic page_e next_page(input page_e cur);
    page_e nxt;
    nxt = PAGE_LO;
    case (cur)
      PAGE_LO: nxt = PAGE_HI;
`ifdef DISP_WR_COUNT_EN
      PAGE_HI: nxt = PAGE_CNT;
`else
      PAGE_HI: nxt = PAGE_LO;
`endif
      default: nxt = PAGE_LO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce counter
// and a one-cycle press pulse on accepted 0->1 transitions.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  assign w_expire = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Pulse coincides with the edge that raises the stable level
  assign press = w_expire & r_sync2;
  assign level = r_level;

endmodule

// File: rtl/disp_value_src.sv
// Feeds one 16-bit page of the CPU display register to the hex display.
// Optional macro DISP_WR_COUNT_EN adds a write counter shown on page 2.
module disp_value_src
  import disp_pkg::*;
#(
  parameter int               DEB_CYCLES  = 1_000_000,
  parameter logic [CAP_W-1:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CAP_W-1:0]  wr_data,
  input  logic              btn_page,
  input  logic              hold,
  output logic [DISP_W-1:0] data,
  output logic [1:0]        page
);

  logic [CAP_W-1:0]  r_capture;
  logic [DISP_W-1:0] r_data;
  page_e             r_page;
  page_e             w_page_next;
  logic [DISP_W-1:0] w_sel;
  logic              w_press;
  logic              w_level_unused;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_page),
    .level   (w_level_unused),
    .press   (w_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_capture <= RESET_VALUE;
    end else if (wr_en) begin
      r_capture <= wr_data;
    end
  end

`ifdef DISP_WR_COUNT_EN
  logic [DISP_W-1:0] r_wr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= '0;
    end else if (wr_en) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_page <= PAGE_LO;
    end else begin
      r_page <= w_page_next;
    end
  end

  always_comb begin
    w_page_next = r_page;
    if (w_press) begin
      w_page_next = next_page(r_page);
    end
  end

  always_comb begin
    w_sel = r_capture[DISP_W-1:0];
    case (r_page)
      PAGE_HI:  w_sel = r_capture[CAP_W-1:DISP_W];
`ifdef DISP_WR_COUNT_EN
      PAGE_CNT: w_sel = r_wr_cnt;
`endif
      default:  w_sel = r_capture[DISP_W-1:0];
    endcase
  end

  // Output lags capture/page by one cycle; hold only freezes this register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= RESET_VALUE[DISP_W-1:0];
    end else if (!hold) begin
      r_data <= w_sel;
    end
  end

  assign data = r_data;

`ifdef DISP_WR_COUNT_EN
  assign page = r_page;
`else
  assign page = {1'b0, r_page[0]};
`endif

endmodule
